if_stage_fetch: RTL

- Instruction-fetch stage directly upstream of the control unit.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Registers each returned word into an IF/ID output register and presents it as if_instr with if_opcode = if_instr[31:26], which feeds the decoder.
- Supports downstream stall, a one-entry skid buffer, and branch/jump redirect with discard of in-flight fetches.

---
 rtl/if_stage_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/if_stage_fetch.sv
// Instruction fetch: PC, imem req/ack handshake, one-entry skid, IF/ID register. MISALIGN_TRAP_EN adds the misaligned-redirect trap.
// Latency: ack to if_valid is 1 cycle; one instruction per cycle with ack every cycle and no stall.
// Backpressure: stall freezes the output register; a word acked under stall parks in the skid and fetching pauses.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] skid_instr, skid_instr_nxt, skid_pc, skid_pc_nxt;
    logic        out_vld_nxt;
    logic [31:0] out_instr_nxt, out_pc_nxt;
    logic        out_free, fetch_ok;
    logic [31:0] redir_pc_al;
    logic        lock;

`ifdef MISALIGN_TRAP_EN
    // lock blocks new fetches from a misaligned redirect until an aligned one arrives
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            lock  <= 1'b0;
            err_q <= 1'b0;
        end else if (redirect) begin
            lock  <= |redirect_pc[1:0];
            err_q <= err_q | (|redirect_pc[1:0]);
        end
    end
    assign fetch_err = err_q;
`else
    assign lock      = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign redir_pc_al = redirect_pc & 32'hFFFF_FFFC;
    assign out_free    = !if_valid || !stall;
    assign fetch_ok    = (state == S_REQ) && !lock;
    // S_DROP must keep presenting the abandoned address until its ack returns
    assign imem_req    = !rst && (fetch_ok || (state == S_DROP));
    assign imem_addr   = (state == S_DROP) ? drop_addr : pc;
    assign if_opcode   = if_instr[31:26];
    assign if_pc_plus4 = if_pc + 32'd4;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drop_addr_nxt  = drop_addr;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        out_vld_nxt    = if_valid;
        out_instr_nxt  = if_instr;
        out_pc_nxt     = if_pc;
        if (if_valid && !stall) begin
            out_vld_nxt   = 1'b0;
            out_instr_nxt = NOP_INSTR;
        end
        if (redirect) begin
            pc_nxt        = redir_pc_al;
            out_vld_nxt   = 1'b0;
            out_instr_nxt = NOP_INSTR;
            case (state)
                S_REQ: begin
                    if (fetch_ok && !imem_ack) begin
                        state_nxt     = S_DROP;
                        drop_addr_nxt = pc;
                    end
                end
                S_HOLD:  state_nxt = S_REQ;
                default: state_nxt = state;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fetch_ok && imem_ack) begin
                        pc_nxt = pc + 32'd4;
                        if (out_free) begin
                            out_vld_nxt   = 1'b1;
                            out_instr_nxt = imem_rdata;
                            out_pc_nxt    = pc;
                        end else begin
                            skid_instr_nxt = imem_rdata;
                            skid_pc_nxt    = pc;
                            state_nxt      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        out_vld_nxt   = 1'b1;
                        out_instr_nxt = skid_instr;
                        out_pc_nxt    = skid_pc;
                        state_nxt     = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) state_nxt = S_REQ;
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop_addr  <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_pc    <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drop_addr  <= drop_addr_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            if_valid   <= out_vld_nxt;
            if_instr   <= out_instr_nxt;
            if_pc      <= out_pc_nxt;
        end
    end

endmodule
